// File: rtl/calc_req_driver_if.sv
// Host and port signal bundle for calc_req_driver.
// The master side is the host/port environment; the slave side is the driver.
interface calc_req_driver_if;
  logic        op_valid;
  logic        op_ready;
  logic [0:3]  op_cmd;
  logic [0:31] op_data1;
  logic [0:31] op_data2;
  logic [0:3]  req_cmd_out;
  logic [0:1]  req_tag_out;
  logic [0:31] req_data_out;
  logic [0:1]  out_resp;
  logic [0:1]  out_tag;
  logic [0:31] out_data;
  logic        cpl_valid;
  logic [0:1]  cpl_resp;
  logic [0:1]  cpl_tag;
  logic [0:31] cpl_data;
  logic        timeout_valid;
  logic [0:1]  timeout_tag;
  logic        stray_resp;
  logic [0:3]  tags_busy;

  modport master (
    output op_valid, op_cmd, op_data1, op_data2,
    output out_resp, out_tag, out_data,
    input  op_ready, req_cmd_out, req_tag_out, req_data_out,
    input  cpl_valid, cpl_resp, cpl_tag, cpl_data,
    input  timeout_valid, timeout_tag, stray_resp, tags_busy
  );

  modport slave (
    input  op_valid, op_cmd, op_data1, op_data2,
    input  out_resp, out_tag, out_data,
    output op_ready, req_cmd_out, req_tag_out, req_data_out,
    output cpl_valid, cpl_resp, cpl_tag, cpl_data,
    output timeout_valid, timeout_tag, stray_resp, tags_busy
  );
endinterface

// File: rtl/calc_req_driver.sv
// Calculator port request driver: two-beat issue, tag allocation,
// response matching and per-tag timeout. State updates on negedge c_clk.
module calc_req_driver #(
  parameter int unsigned TIMEOUT = 255
) (
  input logic              c_clk,
  input logic              reset,
  calc_req_driver_if.slave bus
);
  typedef enum logic {IDLE, DATA2} state_e;

  localparam logic [15:0] AGE_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [0:3]  busy_q, busy_d;
  logic [15:0] age_q [4];
  logic [15:0] age_d [4];
  logic [0:3]  cmd_q, cmd_d;
  logic [0:1]  tag_q, tag_d;
  logic [0:31] data_q, data_d;
  logic [0:31] d2_q, d2_d;
  logic        cpl_v_q, cpl_v_d;
  logic [0:1]  cpl_r_q, cpl_r_d;
  logic [0:1]  cpl_t_q, cpl_t_d;
  logic [0:31] cpl_x_q, cpl_x_d;
  logic        to_v_q, to_v_d;
  logic [0:1]  to_t_q, to_t_d;
  logic        stray_q, stray_d;

  logic        ready;
  logic        accept;
  logic        found;
  logic [0:1]  free_tag;
  logic        resp_hit;

  assign ready  = !reset && state_q == IDLE && busy_q != 4'b1111;
  assign accept = bus.op_valid && ready;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    age_d    = age_q;
    cmd_d    = '0;
    tag_d    = '0;
    data_d   = '0;
    d2_d     = d2_q;
    cpl_v_d  = 1'b0;
    cpl_r_d  = '0;
    cpl_t_d  = '0;
    cpl_x_d  = '0;
    to_v_d   = 1'b0;
    to_t_d   = '0;
    stray_d  = 1'b0;
    found    = 1'b0;
    free_tag = '0;
    resp_hit = 1'b0;

    for (int i = 0; i < 4; i++) begin
      if (!found && !busy_q[i]) begin
        found    = 1'b1;
        free_tag = 2'(i);
      end
    end

    if (bus.out_resp != 2'd0) begin
      if (busy_q[bus.out_tag]) begin
        resp_hit             = 1'b1;
        cpl_v_d              = 1'b1;
        cpl_r_d              = bus.out_resp;
        cpl_t_d              = bus.out_tag;
        cpl_x_d              = bus.out_data;
        busy_d[bus.out_tag]  = 1'b0;
      end else begin
        stray_d = 1'b1;
      end
    end

    // A response on the expiring tag suppresses its timeout.
    for (int i = 0; i < 4; i++) begin
      if (busy_q[i]) begin
        age_d[i] = age_q[i] + 16'd1;
        if (age_q[i] == AGE_LAST && !to_v_d &&
            !(resp_hit && bus.out_tag == 2'(i))) begin
          to_v_d    = 1'b1;
          to_t_d    = 2'(i);
          busy_d[i] = 1'b0;
        end
      end
    end

    unique case (state_q)
      IDLE: begin
        if (accept && bus.op_cmd != 4'd0) begin
          state_d          = DATA2;
          busy_d[free_tag] = 1'b1;
          age_d[free_tag]  = '0;
          cmd_d            = bus.op_cmd;
          tag_d            = free_tag;
          data_d           = bus.op_data1;
          d2_d             = bus.op_data2;
        end
      end
      DATA2: begin
        state_d = IDLE;
        data_d  = d2_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge c_clk) begin
    if (reset) begin
      state_q <= IDLE;
      busy_q  <= '0;
      for (int i = 0; i < 4; i++) age_q[i] <= '0;
      cmd_q   <= '0;
      tag_q   <= '0;
      data_q  <= '0;
      d2_q    <= '0;
      cpl_v_q <= 1'b0;
      cpl_r_q <= '0;
      cpl_t_q <= '0;
      cpl_x_q <= '0;
      to_v_q  <= 1'b0;
      to_t_q  <= '0;
      stray_q <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      age_q   <= age_d;
      cmd_q   <= cmd_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
      d2_q    <= d2_d;
      cpl_v_q <= cpl_v_d;
      cpl_r_q <= cpl_r_d;
      cpl_t_q <= cpl_t_d;
      cpl_x_q <= cpl_x_d;
      to_v_q  <= to_v_d;
      to_t_q  <= to_t_d;
      stray_q <= stray_d;
    end
  end

  assign bus.op_ready      = ready;
  assign bus.req_cmd_out   = cmd_q;
  assign bus.req_tag_out   = tag_q;
  assign bus.req_data_out  = data_q;
  assign bus.cpl_valid     = cpl_v_q;
  assign bus.cpl_resp      = cpl_r_q;
  assign bus.cpl_tag       = cpl_t_q;
  assign bus.cpl_data      = cpl_x_q;
  assign bus.timeout_valid = to_v_q;
  assign bus.timeout_tag   = to_t_q;
  assign bus.stray_resp    = stray_q;
  assign bus.tags_busy     = busy_q;
endmodule

// File: tb/tb_calc_req_driver.sv
// Directed bench for calc_req_driver: TIMEOUT=8 instance for most checks,
// a TIMEOUT=255 twin on the same inputs for the four-tag fill test.
module tb_calc_req_driver;
  logic c_clk = 1'b1;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 c_clk = ~c_clk;

  calc_req_driver_if m ();
  calc_req_driver_if w ();

  assign w.op_valid = m.op_valid;
  assign w.op_cmd   = m.op_cmd;
  assign w.op_data1 = m.op_data1;
  assign w.op_data2 = m.op_data2;
  assign w.out_resp = m.out_resp;
  assign w.out_tag  = m.out_tag;
  assign w.out_data = m.out_data;

  calc_req_driver #(.TIMEOUT(8)) u_dut (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (m.slave)
  );

  calc_req_driver #(.TIMEOUT(255)) u_wide (
    .c_clk (c_clk),
    .reset (reset),
    .bus   (w.slave)
  );

  task automatic nx();
    @(posedge c_clk);
  endtask

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    m.op_valid = 1'b0;
    m.op_cmd   = '0;
    m.op_data1 = '0;
    m.op_data2 = '0;
    m.out_resp = '0;
    m.out_tag  = '0;
    m.out_data = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    nx();
    nx();
    reset = 1'b0;
    nx();
  endtask

  initial begin
    idle_in();
    nx();
    nx();
    chk("rst_ready", 32'(m.op_ready), 0);
    chk("rst_cmd", 32'(m.req_cmd_out), 0);
    chk("rst_data", m.req_data_out, 0);
    chk("rst_busy", 32'(m.tags_busy), 0);
    chk("rst_cpl", 32'(m.cpl_valid), 0);
    reset = 1'b0;
    nx();
    chk("idle_ready", 32'(m.op_ready), 1);

    // single op and its completion
    m.op_valid = 1'b1;
    m.op_cmd   = 4'd1;
    m.op_data1 = 32'd10;
    m.op_data2 = 32'd12;
    nx();
    m.op_valid = 1'b0;
    chk("b1_cmd", 32'(m.req_cmd_out), 1);
    chk("b1_tag", 32'(m.req_tag_out), 0);
    chk("b1_data", m.req_data_out, 10);
    chk("b1_busy", 32'(m.tags_busy), 32'b1000);
    chk("b1_ready", 32'(m.op_ready), 0);
    nx();
    chk("b2_cmd", 32'(m.req_cmd_out), 0);
    chk("b2_data", m.req_data_out, 12);
    chk("b2_ready", 32'(m.op_ready), 1);
    nx();
    chk("b3_data", m.req_data_out, 0);
    m.out_resp = 2'd1;
    m.out_tag  = 2'd0;
    m.out_data = 32'd22;
    nx();
    idle_in();
    chk("cpl_v", 32'(m.cpl_valid), 1);
    chk("cpl_tag", 32'(m.cpl_tag), 0);
    chk("cpl_resp", 32'(m.cpl_resp), 1);
    chk("cpl_data", m.cpl_data, 22);
    chk("cpl_busy", 32'(m.tags_busy), 0);
    nx();
    chk("cpl_pulse", 32'(m.cpl_valid), 0);

    // fill all four tags on the wide twin
    do_reset();
    m.op_valid = 1'b1;
    m.op_cmd   = 4'd2;
    m.op_data1 = 32'd100;
    m.op_data2 = 32'd200;
    for (int n = 0; n < 4; n++) begin
      nx();
      chk("fill_tag", 32'(w.req_tag_out), 32'(n));
      chk("fill_cmd", 32'(w.req_cmd_out), 2);
      nx();
    end
    chk("full_ready", 32'(w.op_ready), 0);
    chk("full_busy", 32'(w.tags_busy), 32'b1111);
    m.out_resp = 2'd1;
    m.out_tag  = 2'd2;
    m.out_data = 32'd5;
    nx();
    m.out_resp = 2'd0;
    chk("free_cpl", 32'(w.cpl_tag), 2);
    chk("free_busy", 32'(w.tags_busy), 32'b1101);
    chk("free_ready", 32'(w.op_ready), 1);
    nx();
    idle_in();
    chk("fifth_tag", 32'(w.req_tag_out), 2);
    chk("fifth_cmd", 32'(w.req_cmd_out), 2);
    chk("fifth_busy", 32'(w.tags_busy), 32'b1111);

    // stray response
    do_reset();
    m.out_resp = 2'd2;
    m.out_tag  = 2'd3;
    m.out_data = 32'd9;
    nx();
    idle_in();
    chk("stray_v", 32'(m.stray_resp), 1);
    chk("stray_cpl", 32'(m.cpl_valid), 0);
    chk("stray_busy", 32'(m.tags_busy), 0);
    nx();
    chk("stray_pulse", 32'(m.stray_resp), 0);

    // timeout after 8 cycles, then tag reuse
    m.op_valid = 1'b1;
    m.op_cmd   = 4'd5;
    m.op_data1 = 32'd1;
    m.op_data2 = 32'd2;
    nx();
    m.op_valid = 1'b0;
    chk("to_busy", 32'(m.tags_busy), 32'b1000);
    for (int c = 0; c < 7; c++) begin
      nx();
      chk("to_early", 32'(m.timeout_valid), 0);
    end
    nx();
    chk("to_v", 32'(m.timeout_valid), 1);
    chk("to_tag", 32'(m.timeout_tag), 0);
    chk("to_free", 32'(m.tags_busy), 0);
    m.op_valid = 1'b1;
    m.op_cmd   = 4'd6;
    nx();
    m.op_valid = 1'b0;
    chk("to_pulse", 32'(m.timeout_valid), 0);
    chk("reuse_tag", 32'(m.req_tag_out), 0);
    chk("reuse_cmd", 32'(m.req_cmd_out), 6);
    for (int c = 0; c < 7; c++) begin
      nx();
      chk("race_early", 32'(m.timeout_valid), 0);
    end
    m.out_resp = 2'd1;
    m.out_tag  = 2'd0;
    m.out_data = 32'd77;
    nx();
    idle_in();
    chk("race_cpl", 32'(m.cpl_valid), 1);
    chk("race_data", m.cpl_data, 77);
    chk("race_to", 32'(m.timeout_valid), 0);
    chk("race_busy", 32'(m.tags_busy), 0);
    nx();
    chk("race_to2", 32'(m.timeout_valid), 0);

    // no-op command
    m.op_valid = 1'b1;
    m.op_cmd   = 4'd0;
    m.op_data1 = 32'd55;
    m.op_data2 = 32'd66;
    chk("nop_ready", 32'(m.op_ready), 1);
    nx();
    chk("nop_cmd", 32'(m.req_cmd_out), 0);
    chk("nop_data", m.req_data_out, 0);
    chk("nop_busy", 32'(m.tags_busy), 0);
    chk("nop_ready2", 32'(m.op_ready), 1);
    nx();
    idle_in();
    chk("nop_data2", m.req_data_out, 0);

    // reset during DATA2 with three tags busy
    do_reset();
    m.op_valid = 1'b1;
    m.op_cmd   = 4'd2;
    m.op_data1 = 32'd3;
    m.op_data2 = 32'd4;
    for (int c = 0; c < 5; c++) nx();
    m.op_valid = 1'b0;
    chk("mid_busy", 32'(m.tags_busy), 32'b1110);
    chk("mid_tag", 32'(m.req_tag_out), 2);
    reset = 1'b1;
    nx();
    chk("mr_data", m.req_data_out, 0);
    chk("mr_busy", 32'(m.tags_busy), 0);
    chk("mr_ready", 32'(m.op_ready), 0);
    reset = 1'b0;
    nx();
    chk("mr_data2", m.req_data_out, 0);
    chk("mr_cpl", 32'(m.cpl_valid), 0);
    chk("mr_ready2", 32'(m.op_ready), 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
